pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Central pipeline controller for the 5-stage core. It collects stall requests from ID and MEM and runs a sequencer for multi-cycle EX operations (mul/div-style). It produces the per-stage stall vector that freezes the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and issues single-cycle flushes with a redirect PC on exceptions. It sits beside the pipeline registers; every stage register takes its hold and clear control from it.

Parameters:
CNT_W, 6, width of the multi-cycle length field (max 2^CNT_W-1 stall cycles)
PC_W, 32, width of the redirect PC

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
stallreq_id  in  1  ID stage hazard stall request (load-use)
stallreq_mem  in  1  MEM stage bus-wait stall request
mc_start  in  1  EX issues a multi-cycle op this cycle
mc_cycles  in  CNT_W  total EX stall cycles for the op (0 treated as 1)
flush_req  in  1  exception/flush request from MEM
flush_pc  in  PC_W  handler address accompanying flush_req
stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold
flush  out  1  clear all pipeline registers (registered, 1-cycle pulse)
new_pc  out  PC_W  redirect PC, valid while flush=1
mc_busy  out  1  multi-cycle op in progress (state RUN)
mc_done  out  1  EX result valid, 1-cycle pulse

Behaviour:
- Reset (async, rst=1): state IDLE, cnt=0, flush=0, new_pc=0, mc_done=0, mc_busy=0, stall=6'b000000.
- FSM states: IDLE, RUN, DONE. cnt is CNT_W bits wide and holds the remaining stall cycles.
- IDLE:
  - mc_start=1 with N=max(mc_cycles,1): EX stall is asserted in the start cycle itself (combinational).
  - N=1: next state DONE.
  - Otherwise: next state RUN with cnt=N-1.
- RUN:
  - EX stall asserted every cycle.
  - cnt decrements each cycle; when cnt==1, next state DONE.
  - mc_start is ignored.
- DONE:
  - mc_done=1 and EX stall released in this cycle.
  - Next state IDLE. A new mc_start in DONE is ignored, so back-to-back ops need a 1-cycle gap.
- Net timing: start in cycle t gives EX stall in cycles t..t+N-1 and mc_done in cycle t+N.
- stall vector (combinational, priority encode):
  - flush=1: 000000.
  - Else stallreq_mem: 011111.
  - Else EX stall (IDLE with mc_start, or RUN): 001111.
  - Else stallreq_id: 000111.
  - Else 000000.
- A MEM stall during RUN does not pause cnt. The sequencer counts wall-clock cycles and the divider unit holds its result.
- flush and new_pc are registered: flush_req in cycle t gives flush=1 and new_pc=flush_pc in cycle t+1, for exactly one cycle. new_pc holds its value afterwards.
- flush_req in any state aborts the sequencer:
  - next state IDLE, cnt=0, no mc_done.
  - flush_req wins over a simultaneous mc_start, which is dropped.
- flush_req asserted for consecutive cycles gives consecutive flush pulses, with new_pc tracking each flush_pc.
- mc_busy = (state==RUN); it is registered-state based and therefore glitch-free.
- rst asserted mid-RUN: immediate return to reset values; no mc_done.

Decomposition:
- Shared defines file:
  - stall vector constants STALL_NONE, STALL_ID, STALL_EX, STALL_MEM
  - FSM state encodings
  - Enable/Disable macros
- One natural sub-module, mc_seq_counter: IDLE/RUN/DONE FSM plus cnt, with outputs ex_stall, mc_busy, mc_done.
- The top level holds the priority encoder and the flush register.

Test Plan:
- Reset then idle: rst pulse asynchronously mid-cycle -> all outputs 0 immediately; stall=000000 with no requests.
- Multi-cycle N=4: mc_start=1, mc_cycles=4 at cycle 10 -> stall=001111 cycles 10-13, mc_busy=1 cycles 11-13, mc_done=1 cycle 14, stall=000000 cycle 14.
- Edge lengths: mc_cycles=0 and 1 -> one stall cycle, mc_done next cycle. mc_cycles=63 -> 63 stall cycles, no wrap.
- Priority: stallreq_id=1 with stallreq_mem=1 -> 011111. During RUN, stallreq_mem=1 -> 011111 and cnt still decrements (mc_done on schedule).
- Flush abort: flush_req=1, flush_pc=0x0000_0020 at cycle 3 of an N=8 op -> cycle 4 flush=1, new_pc=0x20, stall=000000, state IDLE, mc_done never asserted.
- Simultaneous: flush_req and mc_start in the same IDLE cycle -> flush next cycle, no multi-cycle op started, mc_busy stays 0.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: stall vectors, sequencer
// state encodings and enable levels.
package pipe_stall_ctrl_pkg;

  typedef logic [5:0] stall_vec_t;

  // bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold
  localparam stall_vec_t STALL_NONE = 6'b000000;
  localparam stall_vec_t STALL_ID   = 6'b000111;
  localparam stall_vec_t STALL_EX   = 6'b001111;
  localparam stall_vec_t STALL_MEM  = 6'b011111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/pipe_stall_ctrl_mc_seq_counter.sv
// Multi-cycle EX sequencer: counts wall-clock stall cycles for one op and
// pulses mc_done when the result is ready.
//
// state | meaning
// IDLE  | no op; mc_start launches one (EX stalled in the start cycle)
// RUN   | op in flight, EX stalled, cnt = remaining stall cycles
// DONE  | result valid, EX released, mc_start ignored
module mc_seq_counter
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mc_start,
  input  logic [CNT_W-1:0] mc_cycles,
  input  logic             flush_req,
  output logic             ex_stall,
  output logic             mc_busy,
  output logic             mc_done
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_len;
  logic             w_start;

  // A flush in the same cycle drops the start entirely.
  assign w_start = (r_state == S_IDLE) && mc_start && !flush_req;
  assign w_len   = (mc_cycles == '0) ? CNT_ONE : mc_cycles;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush_req) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mc_start) begin
            if (w_len == CNT_ONE) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_RUN;
              w_cnt_nxt   = w_len - CNT_ONE;
            end
          end
        end
        S_RUN: begin
          if (r_cnt == CNT_ONE) begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign ex_stall = w_start || (r_state == S_RUN);
  assign mc_busy  = (r_state == S_RUN) ? ENABLE : DISABLE;
  assign mc_done  = (r_state == S_DONE) ? ENABLE : DISABLE;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: priority-encodes stall requests into the
// per-stage hold vector and registers flush pulses with their redirect PC.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 6,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_mem,
  input  logic             mc_start,
  input  logic [CNT_W-1:0] mc_cycles,
  input  logic             flush_req,
  input  logic [PC_W-1:0]  flush_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [PC_W-1:0]  new_pc,
  output logic             mc_busy,
  output logic             mc_done
);

  logic            w_ex_stall;
  logic            r_flush;
  logic [PC_W-1:0] r_new_pc;

  mc_seq_counter #(
    .CNT_W(CNT_W)
  ) u_mc_seq (
    .clk      (clk),
    .rst      (rst),
    .mc_start (mc_start),
    .mc_cycles(mc_cycles),
    .flush_req(flush_req),
    .ex_stall (w_ex_stall),
    .mc_busy  (mc_busy),
    .mc_done  (mc_done)
  );

  // new_pc keeps the last handler address once the flush pulse ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush  <= DISABLE;
      r_new_pc <= '0;
    end else begin
      r_flush <= flush_req;
      if (flush_req) begin
        r_new_pc <= flush_pc;
      end
    end
  end

  always_comb begin
    stall = STALL_NONE;
    if (r_flush) begin
      stall = STALL_NONE;
    end else if (stallreq_mem) begin
      stall = STALL_MEM;
    end else if (w_ex_stall) begin
      stall = STALL_EX;
    end else if (stallreq_id) begin
      stall = STALL_ID;
    end
  end

  assign flush  = r_flush;
  assign new_pc = r_new_pc;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a cycle-level op model predicts each
// cycle's outputs; a negedge monitor compares them against the DUT.
module tb_pipe_stall_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id;
  logic        stallreq_mem;
  logic        mc_start;
  logic [5:0]  mc_cycles;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_busy;
  logic        mc_done;

  pipe_stall_ctrl #(.CNT_W(6), .PC_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_id (stallreq_id),
    .stallreq_mem(stallreq_mem),
    .mc_start    (mc_start),
    .mc_cycles   (mc_cycles),
    .flush_req   (flush_req),
    .flush_pc    (flush_pc),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .mc_busy     (mc_busy),
    .mc_done     (mc_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        busy;
    logic        done;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: an op is remembered by its start cycle and length; outputs follow
  // from the timeline (EX stall t..t+N-1, busy t+1..t+N-1, done at t+N).
  bit          op_act;
  int          op_start;
  int          op_n;
  bit          m_flush;
  logic [31:0] m_pc;
  int          cyc_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req, input int c);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, c, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("stall",   {26'd0, stall}, {26'd0, e.stall}, e.cyc);
      check("flush",   {31'd0, flush}, {31'd0, e.flush}, e.cyc);
      check("new_pc",  new_pc,          e.pc,             e.cyc);
      check("mc_busy", {31'd0, mc_busy}, {31'd0, e.busy}, e.cyc);
      check("mc_done", {31'd0, mc_done}, {31'd0, e.done}, e.cyc);
    end
  end

  task automatic cyc(input bit id, input bit mem, input bit st, input logic [5:0] n,
                     input bit fr, input logic [31:0] pc);
    exp_t e;
    bit busy, done, ex;
    @(posedge clk);
    #1;
    stallreq_id  = id;
    stallreq_mem = mem;
    mc_start     = st;
    mc_cycles    = n;
    flush_req    = fr;
    flush_pc     = pc;
    busy = op_act && (cyc_n < op_start + op_n);
    done = op_act && (cyc_n == op_start + op_n);
    ex   = busy || (!op_act && st && !fr);
    if (m_flush)  e.stall = 6'b000000;
    else if (mem) e.stall = 6'b011111;
    else if (ex)  e.stall = 6'b001111;
    else if (id)  e.stall = 6'b000111;
    else          e.stall = 6'b000000;
    e.flush = m_flush;
    e.pc    = m_pc;
    e.busy  = busy;
    e.done  = done;
    e.cyc   = cyc_n;
    q.push_back(e);
    if (fr) op_act = 1'b0;
    else if (done) op_act = 1'b0;
    else if (!op_act && st) begin
      op_act   = 1'b1;
      op_start = cyc_n;
      op_n     = (n == 6'd0) ? 1 : int'(n);
    end
    m_flush = fr;
    if (fr) m_pc = pc;
    cyc_n++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 6'd0, 0, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst          = 1'b1;
    stallreq_id  = 1'b0;
    stallreq_mem = 1'b0;
    mc_start     = 1'b0;
    mc_cycles    = 6'd0;
    flush_req    = 1'b0;
    flush_pc     = 32'd0;
    #1;
    check("rst_stall",   {26'd0, stall},  32'd0, cyc_n);
    check("rst_flush",   {31'd0, flush},  32'd0, cyc_n);
    check("rst_new_pc",  new_pc,          32'd0, cyc_n);
    check("rst_mc_busy", {31'd0, mc_busy}, 32'd0, cyc_n);
    check("rst_mc_done", {31'd0, mc_done}, 32'd0, cyc_n);
    op_act  = 1'b0;
    m_flush = 1'b0;
    m_pc    = 32'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int wait_cnt;
    rst = 1'b0;
    stallreq_id = 1'b0; stallreq_mem = 1'b0; mc_start = 1'b0;
    mc_cycles = 6'd0; flush_req = 1'b0; flush_pc = 32'd0;
    op_act = 1'b0; op_start = 0; op_n = 0; m_flush = 1'b0; m_pc = 32'd0; cyc_n = 0;

    do_reset();
    idle(3);
    cyc(0, 0, 1, 6'd4, 0, 32'd0);        // N=4
    idle(5);
    cyc(0, 0, 1, 6'd0, 0, 32'd0);        // 0 treated as 1
    idle(2);
    cyc(0, 0, 1, 6'd1, 0, 32'd0);
    idle(2);
    cyc(0, 0, 1, 6'd63, 0, 32'd0);       // longest op, no wrap
    idle(65);
    cyc(1, 1, 0, 6'd0, 0, 32'd0);
    cyc(1, 0, 0, 6'd0, 0, 32'd0);
    cyc(0, 0, 1, 6'd5, 0, 32'd0);        // MEM stall during RUN
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 6'd0, 0, 32'd0);
    idle(4);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 6'd2, 0, 32'd0);   // starts in RUN/DONE ignored
    idle(3);
    cyc(0, 0, 1, 6'd8, 0, 32'd0);        // flush abort at cycle 3 of op
    idle(2);
    cyc(0, 0, 0, 6'd0, 1, 32'h0000_0020);
    idle(10);
    cyc(0, 0, 1, 6'd5, 1, 32'h0000_0040); // flush beats simultaneous start
    idle(3);
    cyc(0, 0, 0, 6'd0, 1, 32'hAAAA_0000);
    cyc(0, 0, 0, 6'd0, 1, 32'h5555_1234);
    idle(2);
    cyc(0, 0, 1, 6'd10, 0, 32'd0);       // reset mid-RUN
    idle(3);
    do_reset();
    idle(2);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        logic [5:0] n;
        n = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 6));
        cyc($urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 4) == 0,
            n, $urandom_range(0, 24) == 0, $urandom());
      end
    end
    idle(4);

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
